// File: rtl/instr_fetch_if.sv
// Fetch-side bus of the instruction fetch stage: redirect/stall control from the
// pipeline, the instruction-memory address/data pair, and the IF/ID register outputs.
interface instr_fetch_if #(
  parameter int unsigned CNT_W = 32
);
  logic             stall;
  logic             redirect_valid;
  logic [63:0]      redirect_pc;
  logic [63:0]      imem_pc;
  logic [31:0]      imem_inst;
  logic [63:0]      if_id_pc;
  logic [31:0]      if_id_inst;
  logic             if_id_valid;
  logic             fetch_fault;
  logic             misalign;
  logic [CNT_W-1:0] fetch_count;

  modport master (
    input  stall, redirect_valid, redirect_pc, imem_inst,
    output imem_pc, if_id_pc, if_id_inst, if_id_valid, fetch_fault, misalign, fetch_count
  );

  modport slave (
    output stall, redirect_valid, redirect_pc, imem_inst,
    input  imem_pc, if_id_pc, if_id_inst, if_id_valid, fetch_fault, misalign, fetch_count
  );
endinterface

// File: rtl/instr_fetch_stage.sv
// PC generator plus IF/ID pipeline register. Fetches from a combinational
// instruction memory, handles redirects, stalls and out-of-range fetch faults.
module instr_fetch_stage #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int unsigned IMEM_DEPTH = 128,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013,
  parameter int unsigned CNT_W      = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_fetch_if.master bus
);

  typedef enum logic [1:0] {BOOT, RUN, FAULT} state_e;

  state_e           state_q, state_d;
  logic [63:0]      pc_q, pc_d;
  logic [63:0]      if_id_pc_q, if_id_pc_d;
  logic [31:0]      if_id_inst_q, if_id_inst_d;
  logic             if_id_valid_q, if_id_valid_d;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] fetch_count_q, fetch_count_d;

  logic [63:0] redirect_tgt;
  logic        tgt_in_range;
  logic        pc_in_range;

  // Redirect targets are word-aligned by dropping the low two bits.
  assign redirect_tgt = {bus.redirect_pc[63:2], 2'b00};
  assign tgt_in_range = redirect_tgt[63:2] < 62'(IMEM_DEPTH);
  assign pc_in_range  = pc_q[63:2] < 62'(IMEM_DEPTH);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latch).
    state_d       = state_q;
    pc_d          = pc_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_inst_d  = if_id_inst_q;
    if_id_valid_d = if_id_valid_q;
    misalign_d    = 1'b0;
    fetch_count_d = fetch_count_q;

    unique case (state_q)
      BOOT: begin
        state_d = RUN;
        if (bus.redirect_valid) begin
          pc_d          = redirect_tgt;
          if_id_inst_d  = NOP_INST;
          if_id_valid_d = 1'b0;
          misalign_d    = |bus.redirect_pc[1:0];
        end
      end
      RUN: begin
        if (bus.redirect_valid) begin
          // Flush the wrong-path instruction even when stalled.
          pc_d          = redirect_tgt;
          if_id_inst_d  = NOP_INST;
          if_id_valid_d = 1'b0;
          misalign_d    = |bus.redirect_pc[1:0];
        end else if (!pc_in_range) begin
          state_d       = FAULT;
          if_id_inst_d  = NOP_INST;
          if_id_valid_d = 1'b0;
        end else if (!bus.stall) begin
          if_id_pc_d    = pc_q;
          if_id_inst_d  = bus.imem_inst;
          if_id_valid_d = 1'b1;
          pc_d          = pc_q + 64'd4;
          if (!(&fetch_count_q)) fetch_count_d = fetch_count_q + CNT_W'(1);
        end
      end
      FAULT: begin
        if_id_inst_d  = NOP_INST;
        if_id_valid_d = 1'b0;
        if (bus.redirect_valid) begin
          pc_d       = redirect_tgt;
          misalign_d = |bus.redirect_pc[1:0];
          if (tgt_in_range) state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      if_id_pc_q    <= '0;
      if_id_inst_q  <= NOP_INST;
      if_id_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_inst_q  <= if_id_inst_d;
      if_id_valid_q <= if_id_valid_d;
      misalign_q    <= misalign_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign bus.imem_pc     = pc_q;
  assign bus.if_id_pc    = if_id_pc_q;
  assign bus.if_id_inst  = if_id_inst_q;
  assign bus.if_id_valid = if_id_valid_q;
  assign bus.fetch_fault = (state_q == FAULT);
  assign bus.misalign    = misalign_q;
  assign bus.fetch_count = fetch_count_q;

endmodule

// File: doc/instr_fetch_stage.md
Name: instr_fetch_stage

Overview:
- PC generator and IF/ID pipeline register.
- Sits directly upstream of the instruction memory: drives the 64-bit fetch address, takes the 32-bit instruction back combinationally in the same cycle, and registers the pair for the decode stage.
- Handles sequential advance, branch/jump redirects from EX, pipeline stalls and out-of-range fetch faults.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- IMEM_DEPTH, 128, number of 32-bit words in instruction memory; valid fetch range is pc>>2 < IMEM_DEPTH.
- NOP_INST, 32'h00000013, bubble instruction (addi x0,x0,0).
- CNT_W, 32, width of the fetched-instruction counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- stall  in  1  hold PC and IF/ID contents.
- redirect_valid  in  1  taken branch/jump this cycle.
- redirect_pc  in  64  redirect target.
- imem_pc  out  64  fetch address to instruction memory; equals the pc register (combinational).
- imem_inst  in  32  instruction returned for imem_pc in the same cycle.
- if_id_pc  out  64  registered PC of the decode-stage instruction.
- if_id_inst  out  32  registered instruction.
- if_id_valid  out  1  if_id_inst is a real fetched instruction.
- fetch_fault  out  1  sticky; high while in FAULT.
- misalign  out  1  one-cycle pulse; redirect_pc[1:0] was nonzero.
- fetch_count  out  CNT_W  count of instructions latched with valid=1; saturates at all-ones.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, if_id_pc=0, if_id_inst=NOP_INST, if_id_valid=0, fetch_fault=0, misalign=0, fetch_count=0, state=BOOT.
  - Reset mid-operation discards everything immediately.
- States:
  - BOOT: exactly one cycle after rst_n deasserts. pc is held and nothing is latched (valid stays 0). Next state is RUN. A redirect in BOOT is still honoured.
  - RUN: per-cycle priority is redirect > fault detect > stall > advance.
    - Redirect: pc<={redirect_pc[63:2],2'b00}; if_id_inst<=NOP_INST; if_id_valid<=0. The wrong-path instruction is flushed even if stall=1. misalign<=|redirect_pc[1:0]. State stays RUN.
    - Fault detect: if (pc>>2)>=IMEM_DEPTH, go to FAULT; pc held; if_id<=NOP_INST, valid 0.
    - Stall: pc and all IF/ID outputs hold; fetch_count holds.
    - Advance: if_id_pc<=pc; if_id_inst<=imem_inst; if_id_valid<=1; pc<=pc+4 (mod 2^64, wraps FFFF_FFFF_FFFF_FFFC->0); fetch_count+=1 unless saturated.
  - FAULT: fetch_fault=1; pc held; IF/ID forced to NOP_INST with valid 0 every cycle; stall ignored. Exit only by redirect to an in-range target (->RUN, fault cleared the next cycle) or by reset. A redirect to an out-of-range target reloads pc and stays in FAULT.
- Latency: instruction at imem_pc appears on if_id_* one clock later.
- misalign is 0 in every cycle without a misaligned redirect.
- Simultaneous redirect+stall: redirect wins; IF/ID becomes a bubble.

Test Plan:
- Reset release, no stall, memory word n = 32'h1000_0000+n -> BOOT 1 cycle, then if_id_pc 0,4,8 with if_id_inst 10000000,10000001,10000002, valid=1; fetch_count=3.
- At pc=0x10 assert stall 2 cycles -> imem_pc stays 0x10, if_id_pc stays 0x0C, count unchanged; resume -> if_id_pc 0x10.
- redirect_valid with redirect_pc=0x40 while at pc=0x20 -> next cycle imem_pc=0x40, if_id_valid=0, inst=00000013; following cycle if_id_pc=0x40 valid=1.
- redirect_pc=0x102 -> imem_pc=0x100, misalign high exactly one cycle.
- redirect_pc=0x200 (word 128) -> FAULT: fetch_fault=1, valid=0 persistently, stall ignored; redirect_pc=0x0 -> RUN, fault clears, if_id_pc=0 next.
- Drop rst_n asynchronously mid-run at pc=0x30 -> outputs return to reset values before next clk edge; after release BOOT again and fetching restarts at RESET_PC.
